md_issue_scheduler: RTL

//  Shares one pipelined FP32 mul/div unit between two requesters. Performs round-robin arbitration
//  and drives the unit's operand, sel and en inputs. Tracks in-flight ops with a LATENCY-deep tag pipe,

---
 rtl/md_issue_scheduler_if.sv | 41 ++++
 rtl/md_issue_scheduler.sv | 122 ++++++++++++
 2 files changed

// File: rtl/md_issue_scheduler_if.sv
// Bundle of request, unit-side and response signals for md_issue_scheduler.
// slave is the scheduler's view; master is the environment (requesters, unit, consumer).
interface md_issue_scheduler_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_sel;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_sel;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_sel;
    logic        md_en;
    logic [31:0] md_r;
    logic [4:0]  md_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_r;
    logic [4:0]  rsp_flags;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  md_r, md_flags, rsp_ready,
        output req0_ready, req1_ready, md_a, md_b, md_sel, md_en,
        output rsp_valid, rsp_id, rsp_r, rsp_flags
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output md_r, md_flags, rsp_ready,
        input  req0_ready, req1_ready, md_a, md_b, md_sel, md_en,
        input  rsp_valid, rsp_id, rsp_r, rsp_flags
    );
endinterface

// File: rtl/md_issue_scheduler.sv
// Round-robin issue of two requesters onto one pipelined FP32 mul/div unit. A tag pipe
// follows each op through the unit; results return in issue order via a result FIFO whose
// occupancy is guaranteed by issue credits (outstanding ops never exceed FIFO_DEPTH).
module md_issue_scheduler #(
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 arst,
    md_issue_scheduler_if.slave bus
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    // FIFO entry layout: {id, flags[4:0], result[31:0]}
    localparam int unsigned EntW = 38;

    logic            md_en_q;
    logic            rr_q;            // requester preferred when both are valid
    logic [31:0]     md_a_q, md_b_q;
    logic            md_sel_q;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    // Stage 0 runs alongside the operand register, stages 1..LATENCY alongside the unit,
    // so the last stage lines up with md_r/md_flags.
    logic [LATENCY:0] tag_vld_q, tag_id_q;
    logic [EntW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [EntW-1:0]  head;

    logic        credit_ok, grant0, grant1, accept, push, pop, empty;
    logic [31:0] issue_a, issue_b;
    logic        issue_sel;

    // Arbitration and operand selection for this cycle's grant
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        issue_a   = '0;
        issue_b   = '0;
        issue_sel = 1'b0;
        credit_ok = md_en_q && (outstanding_q < CntW'(FIFO_DEPTH));
        if (credit_ok) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = ~rr_q;
                grant1 = rr_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
        if (grant0) begin
            issue_a   = bus.req0_a;
            issue_b   = bus.req0_b;
            issue_sel = bus.req0_sel;
        end else if (grant1) begin
            issue_a   = bus.req1_a;
            issue_b   = bus.req1_b;
            issue_sel = bus.req1_sel;
        end
    end

    assign accept = grant0 | grant1;
    assign empty  = (count_q == '0);
    assign pop    = ~empty & bus.rsp_ready;
    assign push   = tag_vld_q[LATENCY];

    // Next-state for outstanding credits and FIFO occupancy
    always_comb begin
        outstanding_d = outstanding_q;
        count_d       = count_q;
        if (accept && !pop) outstanding_d = outstanding_q + CntW'(1);
        else if (pop && !accept) outstanding_d = outstanding_q - CntW'(1);
        if (push && !pop) count_d = count_q + CntW'(1);
        else if (pop && !push) count_d = count_q - CntW'(1);
    end

    // Issue registers, round-robin pointer, tag pipe and FIFO bookkeeping
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            md_en_q       <= 1'b0;
            rr_q          <= 1'b0;
            md_a_q        <= '0;
            md_b_q        <= '0;
            md_sel_q      <= 1'b0;
            tag_vld_q     <= '0;
            tag_id_q      <= '0;
            outstanding_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            md_en_q       <= 1'b1;
            md_a_q        <= issue_a;
            md_b_q        <= issue_b;
            md_sel_q      <= issue_sel;
            tag_vld_q     <= {tag_vld_q[LATENCY-1:0], accept};
            tag_id_q      <= {tag_id_q[LATENCY-1:0], grant1};
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            if (accept) rr_q <= ~grant1;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // Result storage; stale contents are never visible because the head is gated by empty
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {tag_id_q[LATENCY], bus.md_flags, bus.md_r};
    end

    assign head           = empty ? '0 : fifo_mem[rd_ptr_q];
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.md_a       = md_a_q;
    assign bus.md_b       = md_b_q;
    assign bus.md_sel     = md_sel_q;
    assign bus.md_en      = md_en_q;
    assign bus.rsp_valid  = ~empty;
    assign bus.rsp_id     = head[37];
    assign bus.rsp_flags  = head[36:32];
    assign bus.rsp_r      = head[31:0];
endmodule
